// File: rtl/corr_scan_sequencer.sv
// Raster-scans the correlation engine over every legal template position of a
// captured frame, tracking the best match and guarding against a hung engine.
module corr_scan_sequencer #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int TPL_W       = 32,
    parameter int TPL_H       = 32,
    parameter int TIMEOUT_CYC = 1048576,
    parameter int HB_BITS     = 26
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iFrameDone,
    input  logic        iAbort,
    input  logic        iCorrDone,
    input  logic [31:0] iCorrValue,
    output logic        oCorrStart,
    output logic [12:0] oX,
    output logic [12:0] oY,
    output logic        oBusy,
    output logic        oResultValid,
    output logic [12:0] oXresult,
    output logic [12:0] oYresult,
    output logic [31:0] oBestCorr,
    output logic        oTimeout,
    output logic        oStatusLed
);

    localparam logic [12:0] X_LAST = 13'(H_RES - TPL_W);
    localparam logic [12:0] Y_LAST = 13'(V_RES - TPL_H);
    localparam int          WD_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Trips on the cycle the count would reach TIMEOUT_CYC-1, so ERROR lands
    // exactly TIMEOUT_CYC cycles after the start pulse.
    localparam logic [WD_W-1:0] WD_TRIP = WD_W'(TIMEOUT_CYC - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t            state;
    logic              fdQ;
    logic              fdArmed;
    logic              fdRise;
    logic              startQ;
    logic [WD_W-1:0]   watchdog;
    logic [31:0]       capValue;
    logic [HB_BITS-1:0] heartbeat;

    // A frame already high out of reset must be seen low once before it counts.
    assign fdRise     = iFrameDone & ~fdQ & fdArmed;
    assign oCorrStart = startQ & ~iAbort;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            fdQ     <= 1'b0;
            fdArmed <= 1'b0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            fdQ <= iFrameDone;
            if (!iFrameDone) fdArmed <= 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state        <= S_IDLE;
            startQ       <= 1'b0;
            watchdog     <= '0;
            capValue     <= '0;
            oX           <= '0;
            oY           <= '0;
            oBusy        <= 1'b0;
            oResultValid <= 1'b0;
            oXresult     <= '0;
            oYresult     <= '0;
            oBestCorr    <= '0;
            oTimeout     <= 1'b0;
        end else begin
            startQ <= 1'b0;
            if (iAbort) begin
                state        <= S_IDLE;
                oX           <= '0;
                oY           <= '0;
                oBusy        <= 1'b0;
                oResultValid <= 1'b0;
                oXresult     <= '0;
                oYresult     <= '0;
                oBestCorr    <= '0;
                oTimeout     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (fdRise) begin
                            state        <= S_ISSUE;
                            startQ       <= 1'b1;
                            oBusy        <= 1'b1;
                            oX           <= '0;
                            oY           <= '0;
                            oResultValid <= 1'b0;
                            oXresult     <= '0;
                            oYresult     <= '0;
                            oBestCorr    <= '0;
                            oTimeout     <= 1'b0;
                        end
                    end
                    S_ISSUE: begin
                        state    <= S_WAIT;
                        watchdog <= '0;
                    end
                    S_WAIT: begin
                        if (iCorrDone) begin
                            capValue <= iCorrValue;
                            state    <= S_EVAL;
                        end else if (watchdog == WD_TRIP) begin
                            state    <= S_ERROR;
                            oTimeout <= 1'b1;
                            oBusy    <= 1'b0;
                        end else begin
                            watchdog <= watchdog + 1'b1;
                        end
                    end
                    S_EVAL: begin
                        // Strict compare: ties keep the earlier raster position.
                        if (capValue > oBestCorr) begin
                            oBestCorr <= capValue;
                            oXresult  <= oX;
                            oYresult  <= oY;
                        end
                        state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (oX < X_LAST) begin
                            oX     <= oX + 13'd1;
                            state  <= S_ISSUE;
                            startQ <= 1'b1;
                        end else if (oY < Y_LAST) begin
                            oX     <= '0;
                            oY     <= oY + 13'd1;
                            state  <= S_ISSUE;
                            startQ <= 1'b1;
                        end else begin
                            state        <= S_DONE;
                            oBusy        <= 1'b0;
                            oResultValid <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            heartbeat  <= '0;
            oStatusLed <= 1'b0;
        end else begin
            heartbeat <= heartbeat + 1'b1;
            if (iAbort) begin
                oStatusLed <= 1'b0;
            end else begin
                case (state)
                    S_IDLE:  oStatusLed <= 1'b0;
                    S_DONE:  oStatusLed <= 1'b1;
                    S_ERROR: oStatusLed <= heartbeat[HB_BITS-4];
                    default: oStatusLed <= heartbeat[HB_BITS-1];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_corr_scan_sequencer.sv
// Directed bench for corr_scan_sequencer on a shrunken 8x6 frame with a 4x4 template
// (15 positions); a behavioural engine answers each start after 2 cycles.
module tb_corr_scan_sequencer;

    localparam int H_RES       = 8;
    localparam int V_RES       = 6;
    localparam int TPL_W       = 4;
    localparam int TPL_H       = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int HB_BITS     = 26;
    localparam int NX          = H_RES - TPL_W + 1;
    localparam int NPOS        = NX * (V_RES - TPL_H + 1);

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iFrameDone;
    logic        iAbort;
    logic        iCorrDone;
    logic [31:0] iCorrValue;
    logic        oCorrStart;
    logic [12:0] oX;
    logic [12:0] oY;
    logic        oBusy;
    logic        oResultValid;
    logic [12:0] oXresult;
    logic [12:0] oYresult;
    logic [31:0] oBestCorr;
    logic        oTimeout;
    logic        oStatusLed;

    always #5 iCLK = ~iCLK;

    corr_scan_sequencer #(
        .H_RES(H_RES), .V_RES(V_RES), .TPL_W(TPL_W), .TPL_H(TPL_H),
        .TIMEOUT_CYC(TIMEOUT_CYC), .HB_BITS(HB_BITS)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iFrameDone(iFrameDone), .iAbort(iAbort),
        .iCorrDone(iCorrDone), .iCorrValue(iCorrValue), .oCorrStart(oCorrStart),
        .oX(oX), .oY(oY), .oBusy(oBusy), .oResultValid(oResultValid),
        .oXresult(oXresult), .oYresult(oYresult), .oBestCorr(oBestCorr),
        .oTimeout(oTimeout), .oStatusLed(oStatusLed)
    );

    typedef struct {
        string       name;
        logic [31:0] base;
        logic [31:0] step;
        int          pkA;
        logic [31:0] valA;
        int          pkB;
        logic [31:0] valB;
        int          expX;
        int          expY;
        logic [31:0] expBest;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] engVals [NPOS];
    int          nVec = 0;
    int          nMis = 0;
    longint      cyc  = 0;

    function automatic vec_t mk(input string name, input logic [31:0] base, input logic [31:0] step,
                                input int pkA, input logic [31:0] valA, input int pkB,
                                input logic [31:0] valB, input int expX, input int expY,
                                input logic [31:0] expBest);
        vec_t v;
        v.name = name; v.base = base; v.step = step; v.pkA = pkA; v.valA = valA;
        v.pkB = pkB; v.valB = valB; v.expX = expX; v.expY = expY; v.expBest = expBest;
        return v;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_vals(input vec_t v);
        for (int k = 0; k < NPOS; k++) begin
            if (k == v.pkA)      engVals[k] = v.valA;
            else if (k == v.pkB) engVals[k] = v.valB;
            else                 engVals[k] = v.base + v.step * 32'(k);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_start"},  32'(oCorrStart),   32'd0);
        check({tag, "_x"},      32'(oX),           32'd0);
        check({tag, "_y"},      32'(oY),           32'd0);
        check({tag, "_busy"},   32'(oBusy),        32'd0);
        check({tag, "_valid"},  32'(oResultValid), 32'd0);
        check({tag, "_xres"},   32'(oXresult),     32'd0);
        check({tag, "_yres"},   32'(oYresult),     32'd0);
        check({tag, "_best"},   oBestCorr,         32'd0);
        check({tag, "_tmo"},    32'(oTimeout),     32'd0);
        check({tag, "_led"},    32'(oStatusLed),   32'd0);
    endtask

    task automatic check_result(input string tag, input int x, input int y, input logic [31:0] best,
                                input bit valid);
        check({tag, "_xres"},  32'(oXresult),     32'(x));
        check({tag, "_yres"},  32'(oYresult),     32'(y));
        check({tag, "_best"},  oBestCorr,         best);
        check({tag, "_valid"}, 32'(oResultValid), 32'(valid));
    endtask

    // Raise iFrameDone; one edge later the block sits in ISSUE with results cleared.
    task automatic start_frame(input bit hold);
        iFrameDone = 1'b1;
        tick();
        if (!hold) iFrameDone = 1'b0;
        check("restart_busy",  32'(oBusy),        32'd1);
        check("restart_valid", 32'(oResultValid), 32'd0);
        check("restart_best",  oBestCorr,         32'd0);
        check("restart_tmo",   32'(oTimeout),     32'd0);
    endtask

    task automatic count_starts(input int n, input string name);
        int extra = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (oCorrStart === 1'b1) extra++;
        end
        check(name, 32'(extra), 32'd0);
    endtask

    // Engine model: iCorrDone two cycles after each start. hangAt withholds the reply,
    // abortAt pulses iAbort in WAIT, noise adds stray replies and a frame glitch.
    task automatic run_scan(input int hangAt, input int abortAt, input bit noise);
        int     waitN;
        longint prevStart = 0;
        for (int k = 0; k < NPOS; k++) begin
            waitN = 0;
            while (oCorrStart !== 1'b1 && waitN < 20) begin
                tick();
                waitN++;
            end
            if (oCorrStart !== 1'b1) begin
                check($sformatf("start_seen_k%0d", k), 32'(oCorrStart), 32'd1);
                return;
            end
            check($sformatf("x_k%0d", k), 32'(oX), 32'(k % NX));
            check($sformatf("y_k%0d", k), 32'(oY), 32'(k / NX));
            if (k > 0) check($sformatf("spacing_k%0d", k), 32'(cyc - prevStart), 32'd5);
            prevStart = cyc;
            if (noise) begin
                iCorrDone  = 1'b1;
                iCorrValue = 32'hFFFF_FFFF;
            end
            tick();
            iCorrDone = 1'b0;
            if (noise && k == 7) iFrameDone = 1'b0;
            if (k == abortAt) begin
                iAbort = 1'b1;
                tick();
                iAbort = 1'b0;
                check_zero_outputs("abort");
                count_starts(20, "abort_no_start");
                return;
            end
            if (k == hangAt) begin
                repeat (14) tick();
                check("tmo_early",      32'(oTimeout), 32'd0);
                check("tmo_early_busy", 32'(oBusy),    32'd1);
                tick();
                check("tmo_set",   32'(oTimeout),     32'd1);
                check("tmo_busy",  32'(oBusy),        32'd0);
                check("tmo_valid", 32'(oResultValid), 32'd0);
                return;
            end
            tick();
            if (noise && k == 7) iFrameDone = 1'b1;
            check($sformatf("x_held_k%0d", k), 32'(oX), 32'(k % NX));
            check($sformatf("y_held_k%0d", k), 32'(oY), 32'(k / NX));
            iCorrDone  = 1'b1;
            iCorrValue = engVals[k];
            tick();
            if (noise) iCorrValue = 32'hFFFF_FFFF;
            else       iCorrDone  = 1'b0;
            tick();
            iCorrDone = 1'b0;
            if (k == NPOS - 1) begin
                check("last_next_valid", 32'(oResultValid), 32'd0);
                check("last_next_busy",  32'(oBusy),        32'd1);
                tick();
                check("done_valid", 32'(oResultValid), 32'd1);
                check("done_busy",  32'(oBusy),        32'd0);
                tick();
                check("done_led",   32'(oStatusLed),   32'd1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        vecs[0] = mk("tie",      32'd10, 32'd1,         8, 32'd100,         11, 32'd100,         3, 1, 32'd100);
        vecs[1] = mk("zero",     32'd0,  32'd0,        -1, 32'd0,           -1, 32'd0,           0, 0, 32'd0);
        vecs[2] = mk("ramp",     32'd1,  32'd1,        -1, 32'd0,           -1, 32'd0,           4, 2, 32'd15);
        vecs[3] = mk("unsigned", 32'd5,  32'd0,         3, 32'h8000_0000,    4, 32'hFFFF_FFFF,   4, 0, 32'hFFFF_FFFF);
        vecs[4] = mk("descend",  32'd200, 32'hFFFF_FFFF, -1, 32'd0,          -1, 32'd0,           0, 0, 32'd200);
        vecs[5] = mk("late_max", 32'd3,  32'd0,         6, 32'd50,          13, 32'd51,          3, 2, 32'd51);

        iRST_N     = 1'b0;
        iFrameDone = 1'b0;
        iAbort     = 1'b0;
        iCorrDone  = 1'b0;
        iCorrValue = '0;
        #12;
        check_zero_outputs("reset");
        @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        tick();
        tick();

        // Full scans from the vector table.
        for (int i = 0; i < 6; i++) begin
            load_vals(vecs[i]);
            start_frame(1'b0);
            run_scan(-1, -1, 1'b0);
            check_result(vecs[i].name, vecs[i].expX, vecs[i].expY, vecs[i].expBest, 1'b1);
            count_starts(5, {vecs[i].name, "_no_restart"});
        end

        // Engine hangs at (2,0): best of (0,0),(1,0) held, then a clean restart.
        load_vals(vecs[0]);
        start_frame(1'b0);
        run_scan(2, -1, 1'b0);
        check_result("tmo_hold", 1, 0, 32'd11, 1'b0);
        count_starts(5, "tmo_no_start");
        start_frame(1'b0);
        run_scan(-1, -1, 1'b0);
        check_result("after_tmo", 3, 1, 32'd100, 1'b1);

        // Abort in WAIT at (4,1), then a clean restart.
        start_frame(1'b0);
        run_scan(-1, 9, 1'b0);
        start_frame(1'b0);
        run_scan(-1, -1, 1'b0);
        check_result("after_abort", 3, 1, 32'd100, 1'b1);

        // Abort during ISSUE suppresses the start pulse in that same cycle.
        start_frame(1'b0);
        iAbort = 1'b1;
        #1;
        check("abort_issue_start", 32'(oCorrStart), 32'd0);
        tick();
        iAbort = 1'b0;
        check("abort_issue_busy", 32'(oBusy), 32'd0);
        count_starts(10, "abort_issue_no_start");

        // Frame held high throughout, a glitch rise mid-scan, stray replies outside WAIT.
        start_frame(1'b1);
        run_scan(-1, -1, 1'b1);
        check_result("noise", 3, 1, 32'd100, 1'b1);
        count_starts(20, "held_frame_no_restart");
        iFrameDone = 1'b0;
        tick();

        // Asynchronous reset mid-WAIT, released while the frame is still high.
        start_frame(1'b1);
        tick();
        tick();
        check("pre_reset_busy", 32'(oBusy), 32'd1);
        #2;
        iRST_N = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        tick();
        tick();
        iRST_N = 1'b1;
        count_starts(20, "post_reset_no_start");
        check("post_reset_busy", 32'(oBusy), 32'd0);
        iFrameDone = 1'b0;
        tick();
        load_vals(vecs[5]);
        start_frame(1'b0);
        run_scan(-1, -1, 1'b0);
        check_result("after_reset", 3, 2, 32'd51, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
